// File: rtl/fsctl_nstream.sv
// Frame-synchronous control register bank: host-written staging geometry is committed to all streams on fsync.
// Optional commit interrupt (irq port, W1C flag at index 2) is built when FSCTL_IRQ_EN is defined.
module fsctl_nstream #(
  parameter logic [31:0] C_CORE_VERSION  = 32'hFF01FF00,
  parameter int          C_DATA_WIDTH    = 32,
  parameter int          C_REG_IDX_WIDTH = 8,
  parameter int          C_STREAM_NUM    = 3,
  parameter int          C_IMG_WBITS     = 12,
  parameter int          C_IMG_HBITS     = 12,
  parameter int          C_BUF_NUM       = 4,
  parameter int          C_BUF_IDX_BITS  = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  rd_en,
  input  logic [C_REG_IDX_WIDTH-1:0]            rd_addr,
  output logic [C_DATA_WIDTH-1:0]               rd_data,
  input  logic                                  wr_en,
  input  logic [C_REG_IDX_WIDTH-1:0]            wr_addr,
  input  logic [C_DATA_WIDTH-1:0]               wr_data,
  input  logic                                  fsync,
  output logic                                  o_fsync,
  output logic                                  soft_resetn,
  output logic [C_STREAM_NUM-1:0]               s_running,
  output logic [C_STREAM_NUM*C_IMG_WBITS-1:0]   s_width,
  output logic [C_STREAM_NUM*C_IMG_WBITS-1:0]   s_win_left,
  output logic [C_STREAM_NUM*C_IMG_WBITS-1:0]   s_win_width,
  output logic [C_STREAM_NUM*C_IMG_WBITS-1:0]   s_dst_left,
  output logic [C_STREAM_NUM*C_IMG_WBITS-1:0]   s_dst_width,
  output logic [C_STREAM_NUM*C_IMG_HBITS-1:0]   s_height,
  output logic [C_STREAM_NUM*C_IMG_HBITS-1:0]   s_win_top,
  output logic [C_STREAM_NUM*C_IMG_HBITS-1:0]   s_win_height,
  output logic [C_STREAM_NUM*C_IMG_HBITS-1:0]   s_dst_top,
  output logic [C_STREAM_NUM*C_IMG_HBITS-1:0]   s_dst_height,
`ifdef FSCTL_IRQ_EN
  output logic                                  irq,
`endif
  output logic [C_STREAM_NUM*C_BUF_IDX_BITS-1:0] s_buf_idx
);

  localparam int N  = C_STREAM_NUM;
  localparam int W  = C_IMG_WBITS;
  localparam int H  = C_IMG_HBITS;
  localparam int B  = C_BUF_IDX_BITS;
  localparam int IW = C_REG_IDX_WIDTH;
  localparam int NR = 5;
  localparam logic [IW-1:0] ADDR_CTRL   = IW'(0);
  localparam logic [IW-1:0] ADDR_STATUS = IW'(1);
  localparam logic [IW-1:0] ADDR_IRQ    = IW'(2);
  localparam logic [IW-1:0] ADDR_VER    = '1;
  localparam logic [B-1:0]  BUF_LAST    = B'(C_BUF_NUM - 1);

  logic [N-1:0]  ctrlRun_q;
  logic          ctrlHold_q, ctrlSoft_q;
  logic [W-1:0]  stgX_q [N][NR];
  logic [H-1:0]  stgY_q [N][NR];
  logic [W-1:0]  comX_q [N][NR];
  logic [H-1:0]  comY_q [N][NR];
  logic [N-1:0]  running_q;
  logic [B-1:0]  buf_q [N];
  logic [15:0]   frameCnt_q;
  logic          pending_q, pending_d;
  logic          sync1_q, sync2_q, ofs_q;
  logic [31:0]   rdData_q, rdData_d;
  logic          irqFlag_q, irqFlag_d;
  logic          fsEdge, commit, cfgWr, ctrlWr;
  logic          unusedBits;

  assign fsEdge     = sync1_q & ~sync2_q;
  assign commit     = fsEdge & ~ctrlHold_q;
  assign ctrlWr     = wr_en && (wr_addr == ADDR_CTRL);
  assign unusedBits = ^wr_data;

  // Any staging write (CTRL or stream +0..+4) marks a pending commit; the write beats a same-cycle commit.
  always_comb begin
    cfgWr = ctrlWr;
    for (int s = 0; s < N; s++)
      for (int r = 0; r < NR; r++)
        if (wr_en && (wr_addr == IW'(16 + 8*s + r))) cfgWr = 1'b1;
    pending_d = pending_q;
    if (commit) pending_d = 1'b0;
    if (cfgWr)  pending_d = 1'b1;
  end

`ifdef FSCTL_IRQ_EN
  always_comb begin
    irqFlag_d = irqFlag_q;
    if (wr_en && (wr_addr == ADDR_IRQ) && wr_data[0]) irqFlag_d = 1'b0;
    if (commit) irqFlag_d = 1'b1;
  end
  assign irq = irqFlag_q;
`else
  assign irqFlag_d = 1'b0;
`endif

  always_comb begin
    rdData_d = rdData_q;
    if (rd_en) begin
      rdData_d = '0;
      if (rd_addr == ADDR_CTRL)   rdData_d = 32'({ctrlRun_q, 14'b0, ctrlHold_q, ctrlSoft_q});
      if (rd_addr == ADDR_STATUS) rdData_d = {frameCnt_q, 15'b0, pending_q};
`ifdef FSCTL_IRQ_EN
      if (rd_addr == ADDR_IRQ)    rdData_d = {31'b0, irqFlag_q};
`endif
      if (rd_addr == ADDR_VER)    rdData_d = C_CORE_VERSION;
      for (int s = 0; s < N; s++) begin
        for (int r = 0; r < NR; r++)
          if (rd_addr == IW'(16 + 8*s + r)) rdData_d = {16'(stgX_q[s][r]), 16'(stgY_q[s][r])};
        if (rd_addr == IW'(16 + 8*s + 5)) rdData_d = 32'(buf_q[s]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      ofs_q      <= 1'b0;
      ctrlRun_q  <= '0;
      ctrlHold_q <= 1'b0;
      ctrlSoft_q <= 1'b0;
      running_q  <= '0;
      frameCnt_q <= '0;
      pending_q  <= 1'b0;
      irqFlag_q  <= 1'b0;
      rdData_q   <= '0;
      for (int s = 0; s < N; s++) begin
        buf_q[s] <= '0;
        for (int r = 0; r < NR; r++) begin
          stgX_q[s][r] <= '0;
          stgY_q[s][r] <= '0;
          comX_q[s][r] <= '0;
          comY_q[s][r] <= '0;
        end
      end
    end else begin
      sync1_q   <= fsync;
      sync2_q   <= sync1_q;
      ofs_q     <= fsEdge;
      pending_q <= pending_d;
      irqFlag_q <= irqFlag_d;
      rdData_q  <= rdData_d;
      if (ctrlWr) begin
        ctrlRun_q  <= wr_data[16 +: N];
        ctrlHold_q <= wr_data[1];
        ctrlSoft_q <= wr_data[0];
      end
      if (fsEdge) frameCnt_q <= frameCnt_q + 16'd1;
      if (commit) running_q <= ctrlRun_q;
      // Ring index advances for streams that were running before this edge, even when commits are held.
      for (int s = 0; s < N; s++) begin
        if (fsEdge && running_q[s]) buf_q[s] <= (buf_q[s] == BUF_LAST) ? '0 : buf_q[s] + B'(1);
        for (int r = 0; r < NR; r++) begin
          if (wr_en && (wr_addr == IW'(16 + 8*s + r))) begin
            stgX_q[s][r] <= wr_data[16 +: W];
            stgY_q[s][r] <= wr_data[0 +: H];
          end
          if (commit) begin
            comX_q[s][r] <= ctrlRun_q[s] ? stgX_q[s][r] : '0;
            comY_q[s][r] <= ctrlRun_q[s] ? stgY_q[s][r] : '0;
          end
        end
      end
    end
  end

  always_comb begin
    s_width = '0; s_win_left = '0; s_win_width = '0; s_dst_left = '0; s_dst_width = '0;
    s_height = '0; s_win_top = '0; s_win_height = '0; s_dst_top = '0; s_dst_height = '0;
    s_buf_idx = '0;
    for (int s = 0; s < N; s++) begin
      s_width[s*W +: W]      = comX_q[s][0];
      s_win_left[s*W +: W]   = comX_q[s][1];
      s_win_width[s*W +: W]  = comX_q[s][2];
      s_dst_left[s*W +: W]   = comX_q[s][3];
      s_dst_width[s*W +: W]  = comX_q[s][4];
      s_height[s*H +: H]     = comY_q[s][0];
      s_win_top[s*H +: H]    = comY_q[s][1];
      s_win_height[s*H +: H] = comY_q[s][2];
      s_dst_top[s*H +: H]    = comY_q[s][3];
      s_dst_height[s*H +: H] = comY_q[s][4];
      s_buf_idx[s*B +: B]    = buf_q[s];
    end
  end

  assign rd_data     = rdData_q;
  assign o_fsync     = ofs_q;
  assign soft_resetn = ctrlSoft_q;
  assign s_running   = running_q;

endmodule

// File: tb/tb_fsctl_nstream.sv
// Randomised self-checking bench for fsctl_nstream against a register/frame-level reference model.
// Covers the FSCTL_IRQ_EN interrupt path when that macro is defined for the build.
module tb_fsctl_nstream;

  localparam int N = 3, W = 12, H = 12, B = 2, IW = 8, NBUF = 3;
  localparam logic [31:0] VER = 32'hFF01FF00;

  logic clk = 0, reset = 1, rd_en = 0, wr_en = 0, fsync = 0;
  logic [IW-1:0] rd_addr = 0, wr_addr = 0;
  logic [31:0] wr_data = 0, rd_data;
  logic o_fsync, soft_resetn;
  logic [N-1:0] s_running;
  logic [N*W-1:0] s_width, s_win_left, s_win_width, s_dst_left, s_dst_width;
  logic [N*H-1:0] s_height, s_win_top, s_win_height, s_dst_top, s_dst_height;
  logic [N*B-1:0] s_buf_idx;
`ifdef FSCTL_IRQ_EN
  logic irq;
`endif

  fsctl_nstream #(.C_CORE_VERSION(VER), .C_DATA_WIDTH(32), .C_REG_IDX_WIDTH(IW), .C_STREAM_NUM(N),
                  .C_IMG_WBITS(W), .C_IMG_HBITS(H), .C_BUF_NUM(NBUF), .C_BUF_IDX_BITS(B)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .fsync(fsync), .o_fsync(o_fsync),
    .soft_resetn(soft_resetn), .s_running(s_running),
    .s_width(s_width), .s_win_left(s_win_left), .s_win_width(s_win_width),
    .s_dst_left(s_dst_left), .s_dst_width(s_dst_width),
    .s_height(s_height), .s_win_top(s_win_top), .s_win_height(s_win_height),
    .s_dst_top(s_dst_top), .s_dst_height(s_dst_height),
`ifdef FSCTL_IRQ_EN
    .irq(irq),
`endif
    .s_buf_idx(s_buf_idx));

  always #5 clk = ~clk;

  int checkCount = 0, errorCount = 0;

  // Reference model: register file contents and committed frame state.
  int stgX [N][5], stgY [N][5], comX [N][5], comY [N][5], bufIdx [N];
  int ctrlRun, ctrlHold, ctrlSoft, comRun, frameCnt, pending, irqFlag;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int s = 0; s < N; s++) begin
      bufIdx[s] = 0;
      for (int r = 0; r < 5; r++) begin stgX[s][r] = 0; stgY[s][r] = 0; comX[s][r] = 0; comY[s][r] = 0; end
    end
    ctrlRun = 0; ctrlHold = 0; ctrlSoft = 0; comRun = 0; frameCnt = 0; pending = 0; irqFlag = 0;
  endfunction

  function automatic void modelWrite(input int addr, input logic [31:0] data, input bit withCommit);
    int s, r;
    if (addr == 0) begin
      ctrlRun = int'(data[16 +: N]); ctrlHold = int'(data[1]); ctrlSoft = int'(data[0]); pending = 1;
    end
`ifdef FSCTL_IRQ_EN
    if (addr == 2 && data[0] && !withCommit) irqFlag = 0;
`endif
    if (addr >= 16) begin
      s = (addr - 16) / 8; r = (addr - 16) % 8;
      if (s < N && r < 5) begin
        stgX[s][r] = int'(data[16 +: W]); stgY[s][r] = int'(data[0 +: H]); pending = 1;
      end
    end
  endfunction

  function automatic bit modelFsync();
    frameCnt = (frameCnt + 1) % 65536;
    for (int s = 0; s < N; s++)
      if (comRun[s]) bufIdx[s] = (bufIdx[s] + 1) % NBUF;
    if (ctrlHold != 0) return 0;
    comRun = ctrlRun;
    for (int s = 0; s < N; s++)
      for (int r = 0; r < 5; r++) begin
        comX[s][r] = ctrlRun[s] ? stgX[s][r] : 0;
        comY[s][r] = ctrlRun[s] ? stgY[s][r] : 0;
      end
    pending = 0; irqFlag = 1;
    return 1;
  endfunction

  function automatic logic [31:0] modelRead(input int addr);
    int s, r;
    if (addr == 0) return (32'(ctrlRun) << 16) | (32'(ctrlHold) << 1) | 32'(ctrlSoft);
    if (addr == 1) return (32'(frameCnt) << 16) | 32'(pending);
`ifdef FSCTL_IRQ_EN
    if (addr == 2) return 32'(irqFlag);
`endif
    if (addr == 255) return VER;
    if (addr >= 16) begin
      s = (addr - 16) / 8; r = (addr - 16) % 8;
      if (s < N && r < 5) return (32'(stgX[s][r]) << 16) | 32'(stgY[s][r]);
      if (s < N && r == 5) return 32'(bufIdx[s]);
    end
    return 0;
  endfunction

  task automatic checkState(input string tag);
    logic [N*W-1:0] ex [5];
    logic [N*H-1:0] ey [5];
    logic [N*B-1:0] eb;
    eb = '0;
    for (int r = 0; r < 5; r++) begin ex[r] = '0; ey[r] = '0; end
    for (int s = 0; s < N; s++) begin
      eb[s*B +: B] = B'(bufIdx[s]);
      for (int r = 0; r < 5; r++) begin ex[r][s*W +: W] = W'(comX[s][r]); ey[r][s*H +: H] = H'(comY[s][r]); end
    end
    checkOutput({tag, ".running"}, 64'(s_running), 64'(comRun));
    checkOutput({tag, ".width"}, 64'(s_width), 64'(ex[0]));
    checkOutput({tag, ".win_left"}, 64'(s_win_left), 64'(ex[1]));
    checkOutput({tag, ".win_width"}, 64'(s_win_width), 64'(ex[2]));
    checkOutput({tag, ".dst_left"}, 64'(s_dst_left), 64'(ex[3]));
    checkOutput({tag, ".dst_width"}, 64'(s_dst_width), 64'(ex[4]));
    checkOutput({tag, ".height"}, 64'(s_height), 64'(ey[0]));
    checkOutput({tag, ".win_top"}, 64'(s_win_top), 64'(ey[1]));
    checkOutput({tag, ".win_height"}, 64'(s_win_height), 64'(ey[2]));
    checkOutput({tag, ".dst_top"}, 64'(s_dst_top), 64'(ey[3]));
    checkOutput({tag, ".dst_height"}, 64'(s_dst_height), 64'(ey[4]));
    checkOutput({tag, ".buf_idx"}, 64'(s_buf_idx), 64'(eb));
    checkOutput({tag, ".soft_resetn"}, 64'(soft_resetn), 64'(ctrlSoft));
`ifdef FSCTL_IRQ_EN
    checkOutput({tag, ".irq"}, 64'(irq), 64'(irqFlag));
`endif
  endtask

  // All tasks start and end 1 time unit after a rising clock edge.
  task automatic writeReg(input int addr, input logic [31:0] data);
    wr_en = 1; wr_addr = IW'(addr); wr_data = data;
    @(posedge clk); #1;
    wr_en = 0;
    modelWrite(addr, data, 0);
  endtask

  task automatic readReg(input string tag, input int addr);
    rd_en = 1; rd_addr = IW'(addr);
    @(posedge clk); #1;
    rd_en = 0;
    checkOutput(tag, 64'(rd_data), 64'(modelRead(addr)));
  endtask

  // Raises fsync, optionally writes a register in the exact cycle the synchronised edge is seen.
  task automatic pulseFsync(input string tag, input bit doWrite, input int addr, input logic [31:0] data);
    int lat;
    bit seen, committed;
    lat = 0; seen = 0;
    fsync = 1;
    while (!seen && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (o_fsync) seen = 1;
      if (doWrite && lat == 1) begin wr_en = 1; wr_addr = IW'(addr); wr_data = data; end
      else wr_en = 0;
    end
    wr_en = 0;
    checkOutput({tag, ".ofs_seen"}, 64'(seen), 64'd1);
    checkOutput({tag, ".ofs_lat"}, 64'(lat), 64'd2);
    committed = modelFsync();
    if (doWrite) modelWrite(addr, data, committed);
    checkState(tag);
    fsync = 0;
    @(posedge clk); #1;
    checkOutput({tag, ".ofs_pulse"}, 64'(o_fsync), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;

    checkState("reset");
    readReg("rst_ctrl", 0);
    readReg("rst_status", 1);
    readReg("rst_version", 255);

    // Basic commit of stream 1 size.
    writeReg(24, 32'h0140_00F0);
    writeReg(0, 32'h0002_0001);
    checkOutput("soft_resetn_follow", 64'(soft_resetn), 64'd1);
    readReg("pending_set", 1);
    pulseFsync("commit1", 0, 0, 0);
    checkOutput("s1_width_320", 64'(s_width[W +: W]), 64'd320);
    checkOutput("s1_height_240", 64'(s_height[H +: H]), 64'd240);

    // Held commits.
    writeReg(0, 32'h0002_0003);
    writeReg(24, 32'h0280_01E0);
    pulseFsync("hold1", 0, 0, 0);
    pulseFsync("hold2", 0, 0, 0);
    checkOutput("hold_width", 64'(s_width[W +: W]), 64'd320);
    readReg("hold_status", 1);
    writeReg(0, 32'h0002_0001);
    pulseFsync("release", 0, 0, 0);
    checkOutput("rel_width_640", 64'(s_width[W +: W]), 64'd640);

    // Ring index wrap for stream 0, stream 2 stays stopped.
    writeReg(16, 32'h0064_0032);
    writeReg(0, 32'h0003_0001);
    for (int i = 0; i < 5; i++) pulseFsync("ring", 0, 0, 0);
    readReg("ring_rd_s0", 21);
    readReg("ring_rd_s2", 37);

    // Staging write coincident with the frame edge.
    pulseFsync("coinc", 1, 17, 32'h0011_0022);
    readReg("coinc_status", 1);
    pulseFsync("coinc_next", 0, 0, 0);

    // Read and write of the same index in one cycle returns the old value.
    rd_en = 1; rd_addr = 8'd17; wr_en = 1; wr_addr = 8'd17; wr_data = 32'h0333_0444;
    @(posedge clk); #1;
    rd_en = 0; wr_en = 0;
    checkOutput("rdwr_old", 64'(rd_data), 64'(modelRead(17)));
    modelWrite(17, 32'h0333_0444, 0);
    readReg("rdwr_new", 17);

    // Writes to read-only and unmapped indices are ignored.
    writeReg(1, 32'hFFFF_FFFF);
    writeReg(21, 32'h0000_0003);
    writeReg(22, 32'h1234_5678);
    writeReg(255, 32'h0);
    readReg("ro_status", 1);
    readReg("ro_buf", 21);
    readReg("unmapped", 22);
    readReg("ro_version", 255);

`ifdef FSCTL_IRQ_EN
    writeReg(2, 32'h1);
    checkOutput("irq_clr", 64'(irq), 64'd0);
    pulseFsync("irq_set", 0, 0, 0);
    checkOutput("irq_after_commit", 64'(irq), 64'd1);
    pulseFsync("irq_race", 1, 2, 32'h1);
    checkOutput("irq_set_wins", 64'(irq), 64'd1);
    readReg("irq_rd", 2);
`else
    readReg("irq_idx_zero", 2);
`endif

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      int op, addr;
      logic [31:0] data;
      op = int'($urandom_range(0, 9));
      addr = (op == 9) ? 255 : int'($urandom_range(0, 47));
      data = $urandom;
      if (addr == 0 && $urandom_range(0, 3) != 0) data[1] = 1'b0;
      if (op < 4) writeReg(addr, data);
      else if (op < 7) readReg("rand_rd", addr);
      else pulseFsync("rand_fs", $urandom_range(0, 1) == 1, addr, data);
    end
    readReg("rand_status", 1);

    // Asynchronous reset mid-frame.
    writeReg(0, 32'h0007_0001);
    pulseFsync("pre_rst", 0, 0, 0);
    pulseFsync("pre_rst2", 0, 0, 0);
    fsync = 1;
    @(posedge clk); #1;
    reset = 1;
    #2;
    modelReset();
    checkState("async_rst");
    checkOutput("async_rst.ofs", 64'(o_fsync), 64'd0);
    fsync = 0;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    readReg("post_rst_version", 255);
    readReg("post_rst_status", 1);
    writeReg(32, 32'h0010_0020);
    writeReg(0, 32'h0004_0001);
    pulseFsync("post_rst_commit", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
